// File: rtl/sipo_frame.sv
// sipo_frame: framed serial-in/parallel-out deserializer for the UART receive path.
//
// Collects DW data bits (plus one optional parity bit) strobed in by i_ena/i_val,
// then presents the completed word through a holding register with a valid/ready
// handshake. A parity-error flag travels with the word; a sticky overrun flag
// records words dropped because the holding register was still occupied.
//
// Parameters
//   DW          data bits per frame (2..16)
//   PARITY_EN   1 = one parity bit follows the data bits
//   PARITY_ODD  0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0)
//   MSB_FIRST   0 = first bit lands in o_data[0], 1 = first bit lands in o_data[DW-1]
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   i_clr      synchronous abort/clear, highest priority
//   i_ena      bit strobe; i_val is sampled when high
//   i_val      serial bit
//   i_ready    consumer accepts o_data when high together with o_valid
//   o_data     received word (holding register)
//   o_valid    holding register contains an unconsumed word
//   o_par_err  parity mismatch for the word in o_data
//   o_ovr      sticky overrun flag
//   o_busy     a frame is partially received
module sipo_frame #(
    parameter int unsigned DW         = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned MSB_FIRST  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_ena,
    input  logic          i_val,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    output logic          o_par_err,
    output logic          o_ovr,
    output logic          o_busy
);

    // Frame length in bits and the width needed to count 0..NB.
    localparam int unsigned NB = DW + PARITY_EN;
    localparam int unsigned CW = $clog2(NB + 1);

    localparam logic [CW-1:0] LastCnt = CW'(NB - 1);
    localparam logic [CW-1:0] DataCnt = CW'(DW);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   sr_q, sr_d;
    logic            acc_q, acc_d;
    logic [DW-1:0]   data_q, data_d;
    logic            valid_q, valid_d;
    logic            perr_q, perr_d;
    logic            ovr_q, ovr_d;

    // Datapath helpers
    logic            is_data_bit;
    logic            last_bit;
    logic            frame_done;
    logic            xfer;
    logic            acc_next;
    logic            par_err_new;
    logic [DW-1:0]   sr_shift;
    logic [DW-1:0]   word;

    // Bit-position decode and the candidate completed word.
    always_comb begin
        is_data_bit = (cnt_q < DataCnt);
        last_bit    = (cnt_q == LastCnt);
        frame_done  = i_ena && last_bit;
        xfer        = valid_q && i_ready;
        acc_next    = acc_q ^ i_val;

        if (MSB_FIRST != 0) begin
            sr_shift = {sr_q[DW-2:0], i_val};
        end else begin
            sr_shift = {i_val, sr_q[DW-1:1]};
        end

        // The parity bit never enters the data word; if the final bit is parity
        // the word is whatever the data bits already built up.
        word = is_data_bit ? sr_shift : sr_q;

        if (PARITY_EN != 0) begin
            par_err_new = acc_next ^ 1'(PARITY_ODD);
        end else begin
            par_err_new = 1'b0;
        end
    end

    // Frame FSM: IDLE while no bits of a frame have been taken, SHIFT otherwise.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (i_ena) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (frame_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (i_clr) begin
            state_d = StIdle;
        end
    end

    // Bit counter, shift register, accumulator and holding register.
    always_comb begin
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ovr_d   = ovr_q;

        if (i_ena) begin
            if (is_data_bit) begin
                sr_d = sr_shift;
            end
            if (last_bit) begin
                cnt_d = '0;
                acc_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
                acc_d = acc_next;
            end
        end

        if (frame_done) begin
            // A word accepted on the same edge frees the register for the new one.
            if (!valid_q || i_ready) begin
                data_d  = word;
                perr_d  = par_err_new;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (xfer) begin
            valid_d = 1'b0;
        end

        if (i_clr) begin
            cnt_d   = '0;
            sr_d    = '0;
            acc_d   = 1'b0;
            data_d  = '0;
            valid_d = 1'b0;
            perr_d  = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sr_q    <= '0;
            acc_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_par_err = perr_q;
    assign o_ovr     = ovr_q;
    assign o_busy    = (cnt_q != '0);

endmodule

// File: tb/tb_sipo_frame.sv
// Bench for sipo_frame: five instances with different configurations share one
// stimulus stream; a frame-level model (bit lists, popcount parity) predicts every
// output of every instance each cycle, and directed frames pin literal values.
module tb_sipo_frame;

    localparam int NI = 5;

    logic clk = 1'b0;
    logic rst, i_clr, i_ena, i_val, i_ready;
    logic [7:0] d0, d1, d2, d3;
    logic [4:0] d4;
    logic [NI-1:0] vld, perr, ovr, busy;

    int n_err = 0;
    int n_checks = 0;

    // Instance configurations: DW, PARITY_EN, PARITY_ODD, MSB_FIRST
    int cfg_dw  [NI] = '{8, 8, 8, 8, 5};
    int cfg_pe  [NI] = '{1, 1, 0, 0, 1};
    int cfg_odd [NI] = '{0, 1, 0, 0, 1};
    int cfg_msb [NI] = '{0, 0, 0, 1, 1};

    sipo_frame #(.DW(8), .PARITY_EN(1), .PARITY_ODD(0), .MSB_FIRST(0)) u_even (
        .clk(clk), .rst(rst), .i_clr(i_clr), .i_ena(i_ena), .i_val(i_val),
        .i_ready(i_ready), .o_data(d0), .o_valid(vld[0]), .o_par_err(perr[0]),
        .o_ovr(ovr[0]), .o_busy(busy[0])
    );
    sipo_frame #(.DW(8), .PARITY_EN(1), .PARITY_ODD(1), .MSB_FIRST(0)) u_odd (
        .clk(clk), .rst(rst), .i_clr(i_clr), .i_ena(i_ena), .i_val(i_val),
        .i_ready(i_ready), .o_data(d1), .o_valid(vld[1]), .o_par_err(perr[1]),
        .o_ovr(ovr[1]), .o_busy(busy[1])
    );
    sipo_frame #(.DW(8), .PARITY_EN(0), .PARITY_ODD(0), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .i_clr(i_clr), .i_ena(i_ena), .i_val(i_val),
        .i_ready(i_ready), .o_data(d2), .o_valid(vld[2]), .o_par_err(perr[2]),
        .o_ovr(ovr[2]), .o_busy(busy[2])
    );
    sipo_frame #(.DW(8), .PARITY_EN(0), .PARITY_ODD(0), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .i_clr(i_clr), .i_ena(i_ena), .i_val(i_val),
        .i_ready(i_ready), .o_data(d3), .o_valid(vld[3]), .o_par_err(perr[3]),
        .o_ovr(ovr[3]), .o_busy(busy[3])
    );
    sipo_frame #(.DW(5), .PARITY_EN(1), .PARITY_ODD(1), .MSB_FIRST(1)) u_w5 (
        .clk(clk), .rst(rst), .i_clr(i_clr), .i_ena(i_ena), .i_val(i_val),
        .i_ready(i_ready), .o_data(d4), .o_valid(vld[4]), .o_par_err(perr[4]),
        .o_ovr(ovr[4]), .o_busy(busy[4])
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dut_data(input int k);
        case (k)
            0: return {8'h00, d0};
            1: return {8'h00, d1};
            2: return {8'h00, d2};
            3: return {8'h00, d3};
            4: return {11'h000, d4};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic check(input string name, input int k, input logic [15:0] got,
                         input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] t=%0t got=%h expected=%h", name, k, $time, got, exp);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    int         m_nbits [NI];
    bit         m_bits  [NI][17];
    logic [15:0] m_data [NI];
    bit         m_valid [NI];
    bit         m_perr  [NI];
    bit         m_ovr   [NI];

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_nbits[k] = 0;
            m_data[k]  = 16'h0;
            m_valid[k] = 1'b0;
            m_perr[k]  = 1'b0;
            m_ovr[k]   = 1'b0;
        end
    endtask

    task automatic model_step(input bit clr, input bit ena, input bit val, input bit rdy);
        int nb;
        int ones;
        bit done;
        bit err;
        logic [15:0] w;
        for (int k = 0; k < NI; k++) begin
            nb   = cfg_dw[k] + cfg_pe[k];
            done = 1'b0;
            err  = 1'b0;
            ones = 0;
            w    = 16'h0;
            if (clr) begin
                m_nbits[k] = 0;
                m_data[k]  = 16'h0;
                m_valid[k] = 1'b0;
                m_perr[k]  = 1'b0;
                m_ovr[k]   = 1'b0;
            end else begin
                if (ena) begin
                    m_bits[k][m_nbits[k]] = val;
                    m_nbits[k]++;
                    if (m_nbits[k] == nb) begin
                        done = 1'b1;
                        for (int i = 0; i < cfg_dw[k]; i++) begin
                            if (cfg_msb[k] != 0) w[cfg_dw[k] - 1 - i] = m_bits[k][i];
                            else w[i] = m_bits[k][i];
                        end
                        for (int i = 0; i < nb; i++) ones += int'(m_bits[k][i]);
                        if (cfg_pe[k] != 0) err = ((ones % 2) != cfg_odd[k]);
                        m_nbits[k] = 0;
                    end
                end
                if (done) begin
                    if (!m_valid[k] || rdy) begin
                        m_data[k]  = w;
                        m_perr[k]  = err;
                        m_valid[k] = 1'b1;
                    end else begin
                        m_ovr[k] = 1'b1;
                    end
                end else if (m_valid[k] && rdy) begin
                    m_valid[k] = 1'b0;
                end
            end
        end
    endtask

    // Compare process: advance the model on each rising edge, check 1 time unit later.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst) model_reset();
            else model_step(i_clr, i_ena, i_val, i_ready);
            #1;
            for (int k = 0; k < NI; k++) begin
                check("m_data", k, dut_data(k), m_data[k]);
                check("m_valid", k, {15'h0, vld[k]}, {15'h0, m_valid[k]});
                check("m_perr", k, {15'h0, perr[k]}, {15'h0, m_perr[k]});
                check("m_ovr", k, {15'h0, ovr[k]}, {15'h0, m_ovr[k]});
                check("m_busy", k, {15'h0, busy[k]}, {15'h0, (m_nbits[k] != 0)});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit r, input bit c, input bit e, input bit v, input bit rd);
        rst     = r;
        i_clr   = c;
        i_ena   = e;
        i_val   = v;
        i_ready = rd;
        @(negedge clk);
    endtask

    // n strobes carrying w[0], w[1], ...; i_ready only on the last strobe.
    task automatic send(input logic [15:0] w, input int n, input bit rd_last);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1, w[i], (i == n - 1) ? rd_last : 1'b0);
    endtask

    task automatic check_zero(input string name);
        for (int k = 0; k < NI; k++) begin
            check({name, "_data"}, k, dut_data(k), 16'h0);
            check({name, "_flags"}, k, {11'h0, vld[k], perr[k], ovr[k], busy[k]}, 16'h0);
        end
    endtask

    initial begin
        rst = 1'b0; i_clr = 1'b0; i_ena = 1'b0; i_val = 1'b0; i_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");

        // Basic receive 0xA5 LSB first, parity 0
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(16'h00A5, 9, 1'b0);
        check("a5_data", 0, dut_data(0), 16'h00A5);
        check("a5_valid", 0, {15'h0, vld[0]}, 16'h1);
        check("a5_even_perr", 0, {15'h0, perr[0]}, 16'h0);
        check("a5_odd_perr", 1, {15'h0, perr[1]}, 16'h1);

        // Same data, parity bit 1
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(16'h01A5, 9, 1'b0);
        check("a5p1_data", 0, dut_data(0), 16'h00A5);
        check("a5p1_even_perr", 0, {15'h0, perr[0]}, 16'h1);
        check("a5p1_odd_perr", 1, {15'h0, perr[1]}, 16'h0);

        // Bit order and busy window
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("busy_pre", 2, {15'h0, busy[2]}, 16'h0);
        for (int s = 1; s <= 8; s++) begin
            cyc(1'b1, 1'b0, 1'b1, (s == 1), 1'b0);
            check("busy_win", 2, {15'h0, busy[2]}, {15'h0, (s < 8)});
        end
        check("lsb_first", 2, dut_data(2), 16'h0001);
        check("msb_first", 3, dut_data(3), 16'h0080);
        check("order_valid", 2, {15'h0, vld[2]}, 16'h1);

        // Overrun
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(16'h0011, 8, 1'b0);
        send(16'h0022, 8, 1'b0);
        check("ovr_data", 2, dut_data(2), 16'h0011);
        check("ovr_flag", 2, {15'h0, ovr[2]}, 16'h1);
        check("ovr_valid", 2, {15'h0, vld[2]}, 16'h1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_acc_valid", 2, {15'h0, vld[2]}, 16'h0);
        check("ovr_sticky", 2, {15'h0, ovr[2]}, 16'h1);
        check("ovr_acc_data", 2, dut_data(2), 16'h0011);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ovr_clr", 2, {15'h0, ovr[2]}, 16'h0);

        // Simultaneous accept on completion
        send(16'h0011, 8, 1'b0);
        send(16'h0022, 8, 1'b1);
        check("sim_data", 2, dut_data(2), 16'h0022);
        check("sim_valid", 2, {15'h0, vld[2]}, 16'h1);
        check("sim_ovr", 2, {15'h0, ovr[2]}, 16'h0);

        // Abort after 3 bits, clear wins over a coincident strobe
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(16'h0007, 3, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("abort_busy", 0, {15'h0, busy[0]}, 16'h0);
        check("abort_busy", 2, {15'h0, busy[2]}, 16'h0);
        send(16'h005A, 9, 1'b0);
        check("abort_5a", 2, dut_data(2), 16'h005A);
        check("abort_5a", 0, dut_data(0), 16'h005A);
        check("abort_5a_perr", 0, {15'h0, perr[0]}, 16'h0);

        // Reset mid-frame with a word pending
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(16'h0011, 8, 1'b0);
        send(16'h0007, 5, 1'b0);
        rst = 1'b0;
        #1;
        check_zero("rst_mid");
        @(negedge clk);
        send(16'h00C3, 9, 1'b0);
        check("rst_c3", 0, dut_data(0), 16'h00C3);
        check("rst_c3_perr", 0, {15'h0, perr[0]}, 16'h0);
        check("rst_c3_valid", 0, {15'h0, vld[0]}, 16'h1);
        check("rst_c3", 2, dut_data(2), 16'h00C3);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            cyc(($urandom_range(0, 599) != 0), ($urandom_range(0, 79) == 0),
                ($urandom_range(0, 9) < 6), 1'($urandom), ($urandom_range(0, 3) == 0));
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t simulation did not finish", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sipo_frame.md
# sipo_frame

Parametrised framed serial-in/parallel-out deserializer for the UART receive path. Shifts bits on an enable strobe and counts them into a frame of DW data bits plus an optional parity bit. Bit order and parity polarity are configurable. Completed words are presented through a holding register with a valid/ready handshake, a parity-error flag and a sticky overrun flag. It sits between the bit-sampling logic (which supplies `i_ena`/`i_val`) and the receive FIFO or consumer.

## Interface
- `DW`, 8: data bits per frame; legal range 2..16.
- `PARITY_EN`, 0: 1 = one parity bit follows the data bits.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity; ignored when `PARITY_EN`=0.
- `MSB_FIRST`, 0: 0 = first received bit lands in `o_data[0]`; 1 = first received bit lands in `o_data[DW-1]`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `i_clr` in 1: synchronous abort/clear.
- `i_ena` in 1: bit strobe; sample `i_val` this cycle.
- `i_val` in 1: serial bit.
- `i_ready` in 1: consumer accepts `o_data` when high together with `o_valid`.
- `o_data` out DW: received word from the holding register.
- `o_valid` out 1: holding register contains an unconsumed word.
- `o_par_err` out 1: parity mismatch for the word in `o_data`.
- `o_ovr` out 1: sticky overrun flag.
- `o_busy` out 1: a frame is partially received (bit counter ≠ 0).

## Operation
- Frame length: NB = DW + PARITY_EN bits.
- Bit counter width: $clog2(NB+1).
- States:
  - IDLE: counter = 0.
  - SHIFT: counter in 1..NB-1.
- Transitions:
  - IDLE→SHIFT on `i_ena`.
  - SHIFT→IDLE on `i_ena` when counter = NB-1.
- Data bits, counter 0..DW-1, on `i_ena`:
  - `MSB_FIRST`=0: shift register ← {`i_val`, sr[DW-1:1]}.
  - `MSB_FIRST`=1: shift register ← {sr[DW-2:0], `i_val`}.
  - Running XOR accumulator ^= `i_val`.
- Parity bit, counter = DW, only when `PARITY_EN`=1: not shifted into data; it is only XORed into the accumulator.
- Frame completion is the `i_ena` at counter = NB-1. The completed word is the shift register value including this final bit when it is a data bit.
  - Error flag = accumulator_final XOR `PARITY_ODD` when `PARITY_EN`=1; 0 otherwise.
  - The accumulator and counter return to 0.
- Load rule at completion:
  - If `o_valid`=0, or `o_valid`&`i_ready` in the same cycle: load `o_data`/`o_par_err`, and `o_valid` = 1 (stays 1 on simultaneous accept).
  - Else: the new word is dropped, `o_data` keeps the old word, `o_ovr` ← 1.
- Accept without completion: `o_valid`&`i_ready` → `o_valid` ← 0. `o_data` is retained.
- `o_ovr` clears only on `i_clr` or reset.
- `i_clr` has the highest priority. It zeroes the counter, shift register, accumulator, `o_valid`, `o_par_err`, `o_ovr` and `o_data`. An `i_ena` in the same cycle is discarded.
- `i_ena` low: all state holds. `i_val` is don't-care.

## Timing
- Reset values: `o_data`=0, `o_valid`=0, `o_par_err`=0, `o_ovr`=0, `o_busy`=0; counter, shift register and accumulator are 0.
- Reset asserted mid-frame aborts the frame immediately. After release, the next `i_ena` is bit 0.
- Latency: final-bit `i_ena` sampled at edge N → `o_data`/`o_valid`/`o_par_err` are valid after edge N. Zero extra pipeline cycles.
- Back-to-back `i_ena` on every cycle is supported. Minimum frame time is NB cycles.
- `o_busy` is high after the first bit edge and low after the completion edge.
- `o_ovr` rises after the completion edge that dropped a word.
- Handshake: transfer occurs on an edge where `o_valid`&`i_ready` is true. `o_data` is stable while `o_valid`=1 and no transfer occurs.

## Test plan
- Basic receive, DW=8, PARITY_EN=1, even parity, LSB first: bits 1,0,1,0,0,1,0,1 then parity 0 → `o_data`=0xA5, `o_valid`=1, `o_par_err`=0 after the 9th strobe. Repeat with parity bit 1 → `o_par_err`=1. Repeat with `PARITY_ODD`=1 and parity bit 1 → `o_par_err`=0.
- Bit order, DW=8, PARITY_EN=0: bits 1,0,0,0,0,0,0,0 → `o_data`=0x01 with `MSB_FIRST`=0 and 0x80 with `MSB_FIRST`=1. `o_busy` is high for exactly strobes 1..7.
- Overrun: receive 0x11 and then 0x22 with `i_ready`=0 → `o_data`=0x11, `o_ovr`=1. Then `i_ready`=1 for one cycle → `o_valid`=0 and `o_ovr` remains 1. Then `i_clr` → `o_ovr`=0.
- Simultaneous accept: first frame 0x11 pending; `i_ready`=1 on the completion cycle of frame 0x22 → `o_data`=0x22, `o_valid` stays 1, `o_ovr`=0.
- Abort: `i_clr` (with `i_ena`=1) after 3 bits → counter 0, `o_busy`=0. A following full frame for 0x5A is received exactly.
- Reset mid-frame: assert `rst` low after 5 bits with a word pending → all outputs 0 immediately. After release, frame 0xC3 is received correctly with `o_par_err` computed from those 8 bits only.
